// File: rtl/beta_regfile_sb_if.sv
// rtl/beta_regfile_sb_if.sv - register file write-back, read, scoreboard and clear bundle
// The master side drives addresses, data and issue/clear requests; the slave side is the register file.
interface beta_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
);
    logic              we;
    logic [AW-1:0]     wa;
    logic [XLEN-1:0]   wd;
    logic [NRD*AW-1:0] ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]    rd_pend;
    logic              iss_valid;
    logic [AW-1:0]     iss_dest;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output we, wa, wd, ra, iss_valid, iss_dest, clr_req,
        input  rd, rd_pend, clr_busy, clr_done
    );

    modport slave (
        input  we, wa, wd, ra, iss_valid, iss_dest, clr_req,
        output rd, rd_pend, clr_busy, clr_done
    );
endinterface

// File: rtl/beta_regfile_sb.sv
// rtl/beta_regfile_sb.sv - register file with hard-wired zero register, write-through reads,
// a pending-write scoreboard and a one-entry-per-cycle sequenced clear.
module beta_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = NREG - 1
) (
    input logic             clk,
    input logic             rst,
    beta_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, stateNext;
    logic [AW-1:0]   cidx, cidxNext;
    logic            clrDone, clrDoneNext;
    logic [NREG-1:0] pend, pendNext;
    logic [XLEN-1:0] mem [NREG];
    logic            wrEn, issEn;

    // Addresses naming the zero register or lying past the file behave as absent.
    function automatic logic addrOk(input logic [AW-1:0] a);
        return (a != ZERO_A) && ({1'b0, a} < NREG_W);
    endfunction

    assign wrEn  = bus.we && addrOk(bus.wa) && (state == IDLE);
    assign issEn = bus.iss_valid && addrOk(bus.iss_dest) && (state == IDLE);

    always_comb begin
        stateNext   = state;
        cidxNext    = cidx;
        clrDoneNext = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    stateNext = CLEAR;
                    cidxNext  = '0;
                end
            end
            CLEAR: begin
                // cidx parks on the last entry; the next clear request rewinds it.
                if (cidx == LAST_A) begin
                    stateNext   = IDLE;
                    clrDoneNext = 1'b1;
                end else begin
                    cidxNext = cidx + 1'b1;
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            cidx    <= '0;
            clrDone <= 1'b0;
        end else begin
            state   <= stateNext;
            cidx    <= cidxNext;
            clrDone <= clrDoneNext;
        end
    end

    // A same-cycle issue to the write-back target leaves the entry pending.
    always_comb begin
        pendNext = pend;
        if (state == CLEAR) begin
            pendNext[cidx] = 1'b0;
        end else begin
            if (wrEn)  pendNext[bus.wa]       = 1'b0;
            if (issEn) pendNext[bus.iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= '0;
        else      pend <= pendNext;
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[cidx] <= '0;
        else if (wrEn)      mem[bus.wa] <= bus.wd;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = bus.ra[i*AW +: AW];
        assign hit = (state == IDLE) && addrOk(a);
        assign bus.rd[i*XLEN +: XLEN] = !hit ? '0 :
                                        (bus.we && bus.wa == a) ? bus.wd : mem[a];
        assign bus.rd_pend[i] = hit && pend[a];
    end

    assign bus.clr_busy = (state == CLEAR);
    assign bus.clr_done = clrDone;
endmodule

// File: tb/tb_beta_regfile_sb.sv
// tb/tb_beta_regfile_sb.sv - directed bench for beta_regfile_sb with a behavioural reference model
module tb_beta_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int ZR   = NREG - 1;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    beta_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) bus ();

    beta_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(ZR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: contents, pending flags, and how many clear cycles remain.
    logic [XLEN-1:0] mMem [NREG];
    logic [NREG-1:0] mPend = '0;
    int              clrLeft = NREG;
    int              clrPos  = 0;
    logic            mDone   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            clrLeft <= NREG;
            clrPos  <= 0;
            mPend   <= '0;
            mDone   <= 1'b0;
        end else if (clrLeft > 0) begin
            mMem[clrPos]  <= '0;
            mPend[clrPos] <= 1'b0;
            clrPos        <= clrPos + 1;
            clrLeft       <= clrLeft - 1;
            mDone         <= (clrLeft == 1);
        end else begin
            mDone <= 1'b0;
            if (bus.we && int'(bus.wa) != ZR) begin
                mMem[bus.wa]  <= bus.wd;
                mPend[bus.wa] <= 1'b0;
            end
            if (bus.iss_valid && int'(bus.iss_dest) != ZR) mPend[bus.iss_dest] <= 1'b1;
            if (bus.clr_req) begin
                clrLeft <= NREG;
                clrPos  <= 0;
            end
        end
    end

    function automatic logic [XLEN-1:0] expRd(input int i);
        logic [AW-1:0] a;
        a = bus.ra[i*AW +: AW];
        if (int'(a) == ZR || clrLeft != 0) return '0;
        if (bus.we && bus.wa == a) return bus.wd;
        return mMem[a];
    endfunction

    function automatic logic expPend(input int i);
        logic [AW-1:0] a;
        a = bus.ra[i*AW +: AW];
        if (int'(a) == ZR || clrLeft != 0) return 1'b0;
        return mPend[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("model_rd%0d", i), 64'(bus.rd[i*XLEN +: XLEN]), 64'(expRd(i)));
            check($sformatf("model_pend%0d", i), 64'(bus.rd_pend[i]), 64'(expPend(i)));
        end
        check("model_busy", 64'(bus.clr_busy), 64'(clrLeft != 0));
        check("model_done", 64'(bus.clr_done), 64'(mDone));
    endtask

    task automatic sample();
        @(negedge clk);
        compareModel();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setRa(input int p0, input int p1);
        bus.ra = {AW'(p1), AW'(p0)};
    endtask

    task automatic countClear(input string tag, input int injectAt);
        int busyN = 0;
        int doneN = 0;
        for (int c = 0; c < 40; c++) begin
            bus.clr_req   = (c == injectAt);
            bus.we        = (c == injectAt);
            bus.wa        = 5'd2;
            bus.wd        = 32'h77;
            bus.iss_valid = (c == injectAt);
            bus.iss_dest  = 5'd6;
            sample();
            busyN += int'(bus.clr_busy);
            doneN += int'(bus.clr_done);
            nextCycle();
        end
        bus.clr_req = 1'b0; bus.we = 1'b0; bus.iss_valid = 1'b0;
        check({tag, "_busy_cycles"}, 64'(busyN), 64'd32);
        check({tag, "_done_pulses"}, 64'(doneN), 64'd1);
    endtask

    initial begin
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
        bus.iss_valid = 1'b0; bus.iss_dest = '0; bus.clr_req = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            sample();
            check("reset_busy", 64'(bus.clr_busy), 64'd1);
            check("reset_done", 64'(bus.clr_done), 64'd0);
            nextCycle();
        end
        rst = 1'b1;
        countClear("por", -1);

        for (int a = 0; a < NREG; a++) begin
            setRa(a, NREG - 1 - a);
            sample();
            check("post_clear_rd0", 64'(bus.rd[XLEN-1:0]), 64'd0);
            nextCycle();
        end

        // Write-through bypass, then the stored value after the edge.
        setRa(3, 4);
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hDEADBEEF;
        sample();
        check("bypass_rd0", 64'(bus.rd[XLEN-1:0]), 64'hDEADBEEF);
        nextCycle();
        bus.we = 1'b0;
        sample();
        check("stored_rd0", 64'(bus.rd[XLEN-1:0]), 64'hDEADBEEF);
        nextCycle();

        // Zero register ignores writes and issues.
        setRa(31, 3);
        bus.we = 1'b1; bus.wa = 5'd31; bus.wd = 32'h1234;
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd31;
        sample();
        check("zero_rd_same", 64'(bus.rd[XLEN-1:0]), 64'd0);
        nextCycle();
        bus.we = 1'b0; bus.iss_valid = 1'b0;
        sample();
        check("zero_rd_after", 64'(bus.rd[XLEN-1:0]), 64'd0);
        check("zero_pend", 64'(bus.rd_pend[0]), 64'd0);
        check("r3_kept", 64'(bus.rd[2*XLEN-1:XLEN]), 64'hDEADBEEF);
        nextCycle();

        // Scoreboard: set, set-wins-over-clear, lone clear.
        setRa(5, 6);
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd5;
        sample();
        nextCycle();
        bus.iss_valid = 1'b0;
        sample();
        check("pend_set", 64'(bus.rd_pend[0]), 64'd1);
        nextCycle();
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd5;
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h55;
        sample();
        nextCycle();
        bus.iss_valid = 1'b0; bus.we = 1'b0;
        sample();
        check("pend_set_wins", 64'(bus.rd_pend[0]), 64'd1);
        check("r5_written", 64'(bus.rd[XLEN-1:0]), 64'h55);
        nextCycle();
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h66;
        sample();
        nextCycle();
        bus.we = 1'b0;
        sample();
        check("pend_cleared", 64'(bus.rd_pend[0]), 64'd0);
        check("r5_rewritten", 64'(bus.rd[XLEN-1:0]), 64'h66);
        nextCycle();

        // Clear with a second request, a write and an issue injected mid-sequence.
        bus.we = 1'b1; bus.wa = 5'd1; bus.wd = 32'hA5;
        sample();
        nextCycle();
        bus.we = 1'b0;
        setRa(1, 2);
        sample();
        check("r1_loaded", 64'(bus.rd[XLEN-1:0]), 64'hA5);
        nextCycle();
        bus.clr_req = 1'b1;
        sample();
        nextCycle();
        countClear("clr", 10);
        setRa(1, 2);
        sample();
        check("r1_cleared", 64'(bus.rd[XLEN-1:0]), 64'd0);
        check("r2_write_lost", 64'(bus.rd[2*XLEN-1:XLEN]), 64'd0);
        nextCycle();
        setRa(6, 5);
        sample();
        check("pend6_lost", 64'(bus.rd_pend[0]), 64'd0);
        check("pend5_cleared", 64'(bus.rd_pend[1]), 64'd0);
        check("idle_busy", 64'(bus.clr_busy), 64'd0);
        nextCycle();

        // Reset in the middle of a clear restarts it and drops pending state.
        setRa(9, 0);
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd9;
        sample();
        nextCycle();
        bus.iss_valid = 1'b0;
        sample();
        check("pend9_set", 64'(bus.rd_pend[0]), 64'd1);
        nextCycle();
        bus.clr_req = 1'b1;
        sample();
        nextCycle();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            nextCycle();
        end
        rst = 1'b0;
        sample();
        check("midclr_reset_busy", 64'(bus.clr_busy), 64'd1);
        nextCycle();
        sample();
        nextCycle();
        rst = 1'b1;
        countClear("rst", -1);
        setRa(9, 0);
        sample();
        check("pend9_dropped", 64'(bus.rd_pend[0]), 64'd0);
        check("r0_zero", 64'(bus.rd[2*XLEN-1:XLEN]), 64'd0);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
